// File: rtl/sixty_four_bit_adder.sv
// sixty_four_bit_adder: registered 64-bit adder built from a three-level 4-bit carry-lookahead tree.
// Define ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module sixty_four_bit_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef ADDER_OVF_EN
  ,output logic            ovf
`endif
);

  // Carries 0..4 of a 4-wide lookahead unit; reused at bit, group and block level.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c);
    cla4[0] = c;
    cla4[1] = g[0] | (p[0] & c);
    cla4[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cla4[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cla4[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c);
  endfunction

  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    gen4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [63:0] g, p, c, s;
  logic [15:0] gg, gp, gc;
  logic [3:0]  bg, bp;
  logic [4:0]  bc;

  assign g = a & b;
  assign p = a ^ b;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : grp
      logic [4:0] t;
      assign gg[i] = gen4(g[4*i +: 4], p[4*i +: 4]);
      assign gp[i] = &p[4*i +: 4];
      assign t = cla4(g[4*i +: 4], p[4*i +: 4], gc[i]);
      assign c[4*i +: 4] = t[3:0];
    end
    for (i = 0; i < 4; i++) begin : blk
      logic [4:0] t;
      assign bg[i] = gen4(gg[4*i +: 4], gp[4*i +: 4]);
      assign bp[i] = &gp[4*i +: 4];
      assign t = cla4(gg[4*i +: 4], gp[4*i +: 4], bc[i]);
      assign gc[4*i +: 4] = t[3:0];
    end
  endgenerate

  assign bc = cla4(bg, bp, cin);
  assign s  = p ^ c;

  logic [63:0] sum_q, sum_d;
  logic        cout_q, cout_d, vld_q;

  // Operands are only looked at when qualified, so idle X inputs never reach state.
  always_comb begin
    sum_d  = in_valid ? s : sum_q;
    cout_d = in_valid ? bc[4] : cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = in_valid ? ((a[63] == b[63]) && (s[63] != a[63])) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sixty_four_bit_adder.sv
// tb_sixty_four_bit_adder: randomized bench for sixty_four_bit_adder against a 65-bit arithmetic model.
module tb_sixty_four_bit_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, cin, cout, out_valid;
  logic [63:0] a, b, sum;
`ifdef ADDER_OVF_EN
  logic        ovf;
`endif
  int          n_chk = 0, n_fail = 0;
  logic [63:0] e_sum;
  logic        e_cout, e_vld, e_ovf;

  always #5 clk = ~clk;

  sixty_four_bit_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .out_valid(out_valid)
`ifdef ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"}, sum, e_sum);
    check({tag, ".cout"}, 64'(cout), 64'(e_cout));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_vld));
`ifdef ADDER_OVF_EN
    check({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
`endif
  endtask

  task automatic model_reset();
    e_sum = '0; e_cout = 1'b0; e_vld = 1'b0; e_ovf = 1'b0;
  endtask

  task automatic step(input string tag, input logic v, input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] r;
    @(negedge clk);
    in_valid = v; a = x; b = y; cin = ci;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      e_vld = v;
      if (v) begin
        r = {1'b0, x} + {1'b0, y} + 65'(ci);
        e_sum  = r[63:0];
        e_cout = r[64];
        e_ovf  = (x[63] == y[63]) && (r[63] != x[63]);
      end
    end
    check_all(tag);
  endtask

  initial begin
    logic [63:0] x, y;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    step("in_reset", 1'b1, 64'h1234, 64'h5678, 1'b1);
    #3 rst_n = 1'b1;
    step("post_reset", 1'b0, 'x, 'x, 1'bx);
    step("zero", 1'b1, 64'h0, 64'h0, 1'b0);
    step("pos", 1'b1, 64'h3000000000000000, 64'h4000000000000000, 1'b0);
    step("ovf", 1'b1, 64'h7A140000FFFFFFFF, 64'h66060000FFFFFFFF, 1'b1);
    step("ones", 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    step("hold1", 1'b0, 'x, 'x, 1'bx);
    step("hold2", 1'b0, 'x, 'x, 1'bx);
    step("cin_wrap", 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    step("pre_async", 1'b1, 64'h8000000000000000, 64'h8000000000000000, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    step("rst_sample", 1'b1, 64'hDEADBEEFDEADBEEF, 64'h1, 1'b1);
    #2 rst_n = 1'b1;
    step("post_rst2", 1'b0, 'x, 'x, 1'bx);
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: x = '1;
        1: y = '1;
        2: y = ~x;
        3: x = '0;
        default: ;
      endcase
      step("rand", $urandom_range(0, 4) != 0, x, y, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sixty_four_bit_adder.md
SIXTY_FOUR_BIT_ADDER -- requirements
Module: sixty_four_bit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/sum width; only 64 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  qualifies a, b, cin this cycle.
REQ-005 SHALL have port a  input  64  unsigned addend A.
REQ-006 SHALL have port b  input  64  unsigned addend B.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port sum  output  64  registered result bits [63:0].
REQ-009 SHALL have port cout  output  1  registered carry-out of bit 63.
REQ-010 SHALL have port out_valid  output  1  sum/cout hold a new result this cycle.
REQ-011 SHALL have port ovf  output  1  registered two's-complement overflow; present only when ADDER_OVF_EN is defined.

Function
REQ-012 SHALL compute {cout, sum} = a + b + cin exactly, 65-bit result, no truncation of the carry.
REQ-013 SHALL build the carry path as sixteen 4-bit carry-lookahead groups with group generate/propagate combined by a second lookahead level (4 blocks of 16 bits); no behavioral "+" on the 64-bit datapath.
REQ-014 SHALL register results: inputs sampled at rising edge N with in_valid=1 appear on sum/cout at edge N (visible after edge N), latency 1 cycle.
REQ-015 SHALL set out_valid=1 for exactly the cycle after each in_valid=1 sample; back-to-back in_valid gives one result per cycle, no stalls.
REQ-016 SHALL hold sum/cout (and ovf) unchanged when in_valid=0; out_valid=0 in that cycle.
REQ-017 SHALL wrap modulo 2^64 on sum; cout=1 exactly when a+b+cin >= 2^64.
REQ-018 SHALL treat cin as a full carry into bit 0 including the all-ones case (all-ones + 0 + 1 -> sum 0, cout 1).
REQ-019 SHALL have no X propagation from a, b, cin when in_valid=0.

Reset
REQ-020 SHALL on rst_n=0 immediately (no clock) force sum=0, cout=0, out_valid=0, ovf=0.
REQ-021 SHALL discard any operand sampled in the edge coinciding with or during reset; first result after rst_n rises requires a new in_valid.
REQ-022 SHALL release reset synchronously to clk on the first rising edge with rst_n=1.

Configuration
REQ-023 SHALL, when macro ADDER_OVF_EN is defined, provide port ovf registered with sum: ovf = (a[63]==b[63]) && (sum[63]!=a[63]).
REQ-024 SHALL, when ADDER_OVF_EN is undefined, omit port ovf and all its logic; all other behaviour identical.

Verification
REQ-025 SHALL cover: reset, then a=0, b=0, cin=0, in_valid=1 -> next cycle sum=0, cout=0, out_valid=1, ovf=0.
REQ-026 SHALL cover: a=0x3000000000000000, b=0x4000000000000000, cin=0 -> sum=0x7000000000000000, cout=0, ovf=0.
REQ-027 SHALL cover: a=0x7A140000FFFFFFFF, b=0x66060000FFFFFFFF, cin=1 -> sum=0xE01A0001FFFFFFFF, cout=0, ovf=1.
REQ-028 SHALL cover: a=b=0xFFFFFFFFFFFFFFFF, cin=1 -> sum=0xFFFFFFFFFFFFFFFF, cout=1, ovf=0.
REQ-029 SHALL cover: back-to-back in_valid for REQ-026..028 then in_valid=0 -> three consecutive results, then outputs hold, out_valid=0.
REQ-030 SHALL cover: rst_n driven low mid-stream between clock edges -> sum, cout, out_valid, ovf go 0 immediately; 1000 random operand sets match a 65-bit reference sum.
